// File: rtl/note_playback_reader_pkg.sv
// Shared word layout and sequencer state encoding for the note playback reader.
package note_playback_reader_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   localparam int unsigned DUR_MSB  = 7;
   localparam int unsigned DUR_LSB  = 5;
   localparam int unsigned NOTE_MSB = 4;
   localparam int unsigned NOTE_LSB = 0;

   localparam logic [DATA_WIDTH-1:0] END_WORD = 8'h00;

   typedef enum logic [2:0] {
      StIdle,
      StRewind,
      StReq,
      StWait,
      StPlay,
      StGap,
      StDone
   } state_e;

endpackage

// File: rtl/note_playback_reader_unit_tick_gen.sv
// Prescaler that emits a one-cycle unit_tick every TICKS_PER_UNIT enabled cycles.
module note_playback_reader_unit_tick_gen
   import note_playback_reader_pkg::*;
#(
   parameter int unsigned TICKS_PER_UNIT = 12_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic unit_tick
);

   localparam int unsigned CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_UNIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      unit_tick = en && (cnt_q == CNT_LAST);
      cnt_d     = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = unit_tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/note_playback_reader.sv
// Fetches note words from memory, plays each for its duration, then inserts a
// silent gap before fetching the next word; stops on the end-of-song marker.
module note_playback_reader #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TICKS_PER_UNIT = 12_500_000,
   parameter int unsigned GAP_TICKS      = 1_250_000,
   parameter int unsigned READ_TIMEOUT   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   output logic                  read_en,
   output logic                  read_rst,
   input  logic                  output_ready,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [4:0]            note_out,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);

   import note_playback_reader_pkg::*;

   localparam int unsigned GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam int unsigned WAIT_W = $clog2(READ_TIMEOUT + 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [4:0]          note_q, note_d;
   logic [2:0]          units_q, units_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                terr_q, terr_d;
   logic                tick_en, tick_clr, unit_tick;

   // Prescaler runs only while a note is actually sounding; pause freezes it.
   assign tick_en  = (state_q == StPlay) && !pause;
   assign tick_clr = (state_q != StPlay);

   note_playback_reader_unit_tick_gen #(
      .TICKS_PER_UNIT (TICKS_PER_UNIT)
   ) u_unit_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (tick_en),
      .clr       (tick_clr),
      .unit_tick (unit_tick)
   );

   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      units_d = units_q;
      gap_d   = gap_q;
      wait_d  = wait_q;
      terr_d  = terr_q;

      if (stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StRewind;
                  terr_d  = 1'b0;
               end
            end
            StRewind: state_d = StReq;
            StReq: begin
               wait_d  = '0;
               state_d = StWait;
            end
            StWait: begin
               if (output_ready) begin
                  if (mem_data == DATA_WIDTH'(END_WORD)) begin
                     state_d = StDone;
                  end else begin
                     note_d  = mem_data[NOTE_MSB:NOTE_LSB];
                     units_d = mem_data[DUR_MSB:DUR_LSB];
                     state_d = StPlay;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  terr_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            StPlay: begin
               // units_q holds the remaining units minus one.
               if (unit_tick) begin
                  if (units_q == '0) begin
                     gap_d   = '0;
                     state_d = (GAP_TICKS > 0) ? StGap : StReq;
                  end else begin
                     units_d = units_q - 1'b1;
                  end
               end
            end
            StGap: begin
               if (!pause) begin
                  if (gap_q == GAP_LAST) begin
                     state_d = StReq;
                  end else begin
                     gap_d = gap_q + 1'b1;
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      read_rst    = (state_q == StRewind);
      read_en     = (state_q == StReq);
      done        = (state_q == StDone);
      busy        = (state_q != StIdle);
      timeout_err = terr_q;
      note_out    = '0;
      if ((state_q == StPlay) && !pause) begin
         note_out = note_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         note_q  <= '0;
         units_q <= '0;
         gap_q   <= '0;
         wait_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         note_q  <= note_d;
         units_q <= units_d;
         gap_q   <= gap_d;
         wait_q  <= wait_d;
         terr_q  <= terr_d;
      end
   end

endmodule

// File: tb/tb_note_playback_reader.sv
// Directed bench for note_playback_reader with a one-cycle-latency memory model.
module tb_note_playback_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, pause;
   logic       read_en, read_rst, output_ready;
   logic [7:0] mem_data;
   logic [4:0] note_out;
   logic       busy, done, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   note_playback_reader #(
      .DATA_WIDTH     (8),
      .TICKS_PER_UNIT (4),
      .GAP_TICKS      (2),
      .READ_TIMEOUT   (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .pause        (pause),
      .read_en      (read_en),
      .read_rst     (read_rst),
      .output_ready (output_ready),
      .mem_data     (mem_data),
      .note_out     (note_out),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err)
   );

   // Memory model: answers output_ready one cycle after read_en.
   logic [7:0] mem [0:3];
   int         ptr = 0;
   logic       pend = 1'b0;
   logic       mem_silent = 1'b0;

   initial begin
      output_ready = 1'b0;
      mem_data     = 8'h00;
   end

   always @(negedge clk) begin
      if (read_rst) ptr = 0;
      if (pend && !mem_silent) begin
         output_ready = 1'b1;
         mem_data     = mem[ptr];
         ptr          = ptr + 1;
      end else begin
         output_ready = 1'b0;
         mem_data     = 8'h00;
      end
      pend = read_en;
   end

   // Per-cycle trace; index i is the i-th cycle after the start cycle.
   logic       tr_rst  [0:63];
   logic       tr_en   [0:63];
   logic [4:0] tr_note [0:63];
   logic       tr_busy [0:63];
   logic       tr_done [0:63];
   logic       tr_terr [0:63];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_trace(input int n, input int p_lo, input int p_hi, input int stop_cyc);
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         start      = 1'b0;
         tr_rst[i]  = read_rst;
         tr_en[i]   = read_en;
         tr_note[i] = note_out;
         tr_busy[i] = busy;
         tr_done[i] = done;
         tr_terr[i] = timeout_err;
         pause      = (i >= p_lo) && (i < p_hi);
         stop       = (i == stop_cyc);
      end
      pause = 1'b0;
      stop  = 1'b0;
   endtask

   function automatic int count_note(input int n, input logic [4:0] v);
      int c = 0;
      for (int i = 1; i <= n; i++) if (tr_note[i] == v) c++;
      return c;
   endfunction

   function automatic int count_en(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) if (tr_en[i]) c++;
      return c;
   endfunction

   function automatic int count_done(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) if (tr_done[i]) c++;
      return c;
   endfunction

   typedef struct {
      int         lo;
      int         hi;
      logic       rst;
      logic       en;
      logic [4:0] note;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{1,  1,  1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[1] = '{2,  2,  1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
      tbl[2] = '{3,  3,  1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[3] = '{4,  11, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0};
      tbl[4] = '{12, 13, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[5] = '{14, 14, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
      tbl[6] = '{15, 15, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[7] = '{16, 16, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1};
      tbl[8] = '{17, 20, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      #3;
      check("reset_outputs", {read_en, read_rst, note_out, busy, done, timeout_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic song: one note then end marker, cycle-exact table.
      mem[0] = 8'h25;
      mem[1] = 8'h00;
      run_trace(20, 0, 0, 0);
      for (int v = 0; v < 9; v++) begin
         for (int c = tbl[v].lo; c <= tbl[v].hi; c++) begin
            check($sformatf("basic_c%0d", c),
                  {tr_rst[c], tr_en[c], tr_note[c], tr_busy[c], tr_done[c]},
                  {tbl[v].rst, tbl[v].en, tbl[v].note, tbl[v].busy, tbl[v].done});
         end
      end

      // Longest duration: 8 units of 4 cycles.
      mem[0] = 8'hE3;
      mem[1] = 8'h00;
      run_trace(44, 0, 0, 0);
      check("long_note_cycles", count_note(44, 5'd3), 32);
      check("long_first", tr_note[4], 5'd3);
      check("long_last", tr_note[35], 5'd3);
      check("long_gap", tr_note[36], 5'd0);
      check("long_read_en_count", count_en(44), 2);
      check("long_done_c40", tr_done[40], 1'b1);
      check("long_no_timeout", tr_terr[44], 1'b0);

      // Memory never answers: timeout after 8 wait cycles, then start clears it.
      mem_silent = 1'b1;
      run_trace(14, 0, 0, 0);
      check("to_not_yet_c10", tr_terr[10], 1'b0);
      check("to_set_c11", tr_terr[11], 1'b1);
      check("to_idle_c11", tr_busy[11], 1'b0);
      check("to_note_silent", count_note(14, 5'd0), 14);
      check("to_no_done", count_done(14), 0);
      check("to_single_read", count_en(14), 1);
      mem_silent = 1'b0;
      mem[0] = 8'h25;
      mem[1] = 8'h00;
      run_trace(20, 0, 0, 0);
      check("to_cleared_by_start", tr_terr[1], 1'b0);
      check("to_recover_done", tr_done[16], 1'b1);

      // Pause for five cycles mid-note.
      run_trace(24, 5, 10, 0);
      check("pause_note_total", count_note(24, 5'd5), 8);
      check("pause_muted_c8", tr_note[8], 5'd0);
      check("pause_resumed_c11", tr_note[11], 5'd5);
      check("pause_last_c16", tr_note[16], 5'd5);
      check("pause_done_c21", tr_done[21], 1'b1);

      // Stop together with output_ready in WAIT.
      run_trace(12, 0, 0, 3);
      check("stop_idle_c4", tr_busy[4], 1'b0);
      check("stop_no_note", count_note(12, 5'd0), 12);
      check("stop_no_done", count_done(12), 0);
      check("stop_one_read", count_en(12), 1);

      // Asynchronous reset between clock edges mid-note.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("arst_playing_c6", note_out, 5'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_outputs_zero", {read_en, read_rst, note_out, busy, done, timeout_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int en_seen = 0;
         int busy_seen = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (read_en) en_seen++;
            if (busy) busy_seen++;
         end
         check("arst_no_read_en", en_seen, 0);
         check("arst_stays_idle", busy_seen, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
